gate_sweep_checker: RTL and testbench

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_chk_pkg.sv | 14 +
 rtl/settle_timer.sv | 27 ++
 rtl/gate_sweep_checker.sv | 99 +++++++++
 tb/tb_gate_sweep_checker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared states and constants for the gate sweep checker
package gate_chk_pkg;

    localparam int NUM_VEC = 4;
    localparam int VEC_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable count-down timer, expire is high on the last held cycle
module settle_timer #(
    parameter int unsigned CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [3:0] count;

    // Loading CYCLES-1 makes expire rise on the CYCLES-th enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= 4'(CYCLES - 1);
        end else if (en && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign expire = en && (count == 4'd0);

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - drives a 2-input gate through 00,01,10,11 and checks Y; GATE_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned          SETTLE = 2,
    parameter logic [NUM_VEC-1:0]   EXPECT = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count
);

    state_t            state, state_next;
    logic [VEC_W-1:0]  vec, vec_next;
    logic [2:0]        err_next, err_inc;
    logic              pass_next;
    logic              load, expire, mismatch, stop;

    settle_timer #(.CYCLES(SETTLE)) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .en     (state == S_SETTLE),
        .expire (expire)
    );

    assign mismatch = (Y != EXPECT[vec]);
    assign err_inc  = err_count + 3'(mismatch);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    assign stop = mismatch;
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vec       <= '0;
            err_count <= 3'd0;
            pass      <= 1'b0;
        end else begin
            state     <= state_next;
            vec       <= vec_next;
            err_count <= err_next;
            pass      <= pass_next;
        end
    end

    always_comb begin
        state_next = state;
        vec_next   = vec;
        err_next   = err_count;
        pass_next  = pass;
        load       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                // DONE behaves like IDLE so a held start chains sweeps back to back.
                vec_next   = '0;
                state_next = S_IDLE;
                if (start) begin
                    state_next = S_SETTLE;
                    err_next   = 3'd0;
                    pass_next  = 1'b0;
                    load       = 1'b1;
                end
            end
            S_SETTLE: begin
                if (expire) state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                err_next = err_inc;
                if (vec == VEC_W'(NUM_VEC - 1) || stop) begin
                    state_next = S_DONE;
                    vec_next   = '0;
                    pass_next  = (err_inc == 3'd0);
                end else begin
                    state_next = S_SETTLE;
                    vec_next   = vec + 1'b1;
                    load       = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign A    = vec[1];
    assign B    = vec[0];
    assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - scoreboard bench: AND checker (SETTLE=2) and OR checker (SETTLE=1)
module tb_gate_sweep_checker;

    typedef struct {
        int lat;
        int err;
        bit pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1, stuck;
    logic       y0, a0, b0, busy0, done0, pass0;
    logic       y1, a1, b1, busy1, done1, pass1;
    logic [2:0] err0, err1;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign y0 = stuck ? 1'b1 : (a0 & b0);
    assign y1 = a1 | b1;

    gate_sweep_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .Y(y0),
        .A(a0), .B(b0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
    );

    gate_sweep_checker #(.SETTLE(1), .EXPECT(4'b1110)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .Y(y1),
        .A(a1), .B(b1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
    );

    function automatic logic get_done(input int which);
        return (which != 0) ? done1 : done0;
    endfunction
    function automatic logic get_busy(input int which);
        return (which != 0) ? busy1 : busy0;
    endfunction
    function automatic logic get_pass(input int which);
        return (which != 0) ? pass1 : pass0;
    endfunction
    function automatic logic [2:0] get_err(input int which);
        return (which != 0) ? err1 : err0;
    endfunction
    function automatic logic [1:0] get_ab(input int which);
        return (which != 0) ? {a1, b1} : {a0, b0};
    endfunction

    // Independent reference: walks the truth table of the attached gate.
    function automatic exp_t model(input int which, input bit f1);
        exp_t       e;
        int         s;
        logic [3:0] ex;
        logic [1:0] vv;
        logic       y;
        s     = (which != 0) ? 1 : 2;
        ex    = (which != 0) ? 4'b1110 : 4'b1000;
        e.err = 0;
        e.lat = 4 * (s + 1);
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            y  = (which != 0) ? (vv[1] | vv[0]) : (f1 ? 1'b1 : (vv[1] & vv[0]));
            if (y != ex[v]) begin
                e.err++;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                e.lat = (v + 1) * (s + 1);
                break;
`endif
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic kick(input int which);
        if (which != 0) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        if (which != 0) start1 = 1'b0; else start0 = 1'b0;
    endtask

    // Entered at the negedge right after the accepting edge (m=0).
    task automatic observe_sweep(input int which, input string name);
        exp_t e;
        int   s, m;
        bit   seen;
        e    = sb.pop_front();
        s    = (which != 0) ? 1 : 2;
        m    = 0;
        seen = 1'b0;
        while (m <= 4 * (s + 1) + 2) begin
            if (get_done(which)) begin
                seen = 1'b1;
                break;
            end
            if (m < e.lat) begin
                checks++;
                if (get_busy(which) !== 1'b1 || get_ab(which) !== 2'(m / (s + 1))) begin
                    errors++;
                    $display("FAIL %s trace m=%0d: busy=%b AB=%b, required busy=1 AB=%b",
                             name, m, get_busy(which), get_ab(which), 2'(m / (s + 1)));
                end
            end
            @(negedge clk);
            m++;
        end
        checks++;
        if (!seen || m != e.lat) begin
            errors++;
            $display("FAIL %s latency: done seen=%0d at cycle %0d, required cycle %0d", name, seen, m, e.lat);
        end
        checks++;
        if (get_err(which) !== 3'(e.err)) begin
            errors++;
            $display("FAIL %s err_count: got %0d, required %0d", name, get_err(which), e.err);
        end
        checks++;
        if (get_pass(which) !== e.pass || get_busy(which) !== 1'b0) begin
            errors++;
            $display("FAIL %s pass/busy at done: got %b/%b, required %b/0", name, get_pass(which), get_busy(which), e.pass);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({a0, b0, busy0, done0, pass0, err0} !== 8'd0) begin
            errors++;
            $display("FAIL reset_held: A,B,busy,done,pass,err=%b, required 0", {a0, b0, busy0, done0, pass0, err0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy0, done0, busy1, done1, a0, b0} !== 6'd0) begin
            errors++;
            $display("FAIL reset_release: busy/done/A/B=%b, required 0", {busy0, done0, busy1, done1, a0, b0});
        end
    endtask

    task automatic test_and_sweep();
        stuck = 1'b0;
        sb.push_back(model(0, 1'b0));
        kick(0);
        observe_sweep(0, "and_sweep");
    endtask

    task automatic test_stuck_high();
        stuck = 1'b1;
        sb.push_back(model(0, 1'b1));
        kick(0);
        observe_sweep(0, "stuck_high");
        stuck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        bit f1;
        bit bad;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        f1 = 1'b0;
`else
        f1 = 1'b1;
`endif
        stuck = f1;
        kick(0);
        repeat (7) @(negedge clk);
        checks++;
        if ({a0, b0} !== 2'b10 || err0 !== (f1 ? 3'd2 : 3'd0) || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_pre: AB=%b err=%0d busy=%b, required AB=10 err=%0d busy=1", {a0, b0}, err0, busy0, f1 ? 2 : 0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a0, b0, busy0, done0, pass0, err0} !== 8'd0) begin
            errors++;
            $display("FAIL mid_sweep_reset: A,B,busy,done,pass,err=%b, required 0", {a0, b0, busy0, done0, pass0, err0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        stuck = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mid_sweep_quiet: done or busy rose after reset, required none");
        end
    endtask

    task automatic test_start_while_busy();
        sb.push_back(model(0, 1'b0));
        kick(0);
        fork
            observe_sweep(0, "start_while_busy");
            begin
                repeat (4) @(negedge clk);
                start0 = 1'b1;
                @(negedge clk);
                start0 = 1'b0;
                repeat (3) @(negedge clk);
                start0 = 1'b1;
                @(negedge clk);
                start0 = 1'b0;
            end
        join
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy_after: busy=%b done=%b, required 0/0", busy0, done0);
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back(model(0, 1'b0));
        sb.push_back(model(0, 1'b0));
        start0 = 1'b1;
        @(negedge clk);
        observe_sweep(0, "b2b_first");
        @(negedge clk);
        start0 = 1'b0;
        observe_sweep(0, "b2b_second");
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b, required 0", busy0);
        end
    endtask

    task automatic test_or_gate();
        sb.push_back(model(1, 1'b0));
        kick(1);
        observe_sweep(1, "or_settle1");
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        stuck  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_and_sweep();
        test_stuck_high();
        test_reset_mid_sweep();
        test_start_while_busy();
        test_back_to_back();
        test_or_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
